fx2_slave_fifo_responder: RTL and testbench
===========================================

// Module: fx2_slave_fifo_responder
// PURPOSE
//  Synthesizable FX2-side responder for the 16-bit slave-FIFO bus: it plays the part of the
//  FX2 chip facing our FPGA slave-FIFO master. EP2 (OUT, host->FPGA) is loaded from a host-side
//  write port and read by the master. EP6 (IN, FPGA->host) is written by the master and drained
//  by a host-side read port. Used for on-board loopback and as the DUT partner in master benches.
// PARAMETERS
//  DEPTH_LOG2  9    log2 words per endpoint FIFO (512 words each)
//  PKT_WORDS   256  EP6 auto-commit size in words (512 bytes); 1..2**DEPTH_LOG2
// PORTS
//  CLK          in   1   single clock; all bus and host signals are synchronous to it
//  RST          in   1   asynchronous active-low reset
//  FD           inout 16 slave-FIFO data bus
//  SLOE         in   1   1 = master releases FD; responder drives FD
//  SLRD         in   1   1-cycle read strobe
//  SLWR         in   1   1-cycle write strobe
//  FIFOADR      in   2   2'b00 = EP2, 2'b10 = EP6; other codes select nothing
//  PKTEND       in   1   commit partial EP6 packet
//  FLAG_EMPTY   out  1   1 = EP2 empty (fixed to EP2, independent of FIFOADR)
//  FLAG_FULL    out  1   1 = EP6 full (fixed to EP6, independent of FIFOADR)
//  host_wr_data in   16  word pushed into EP2
//  host_wr_en   in   1   push strobe; ignored while host_full
//  host_full    out  1   EP2 full
//  host_rd_data out  16  EP6 head word (first-word-fall-through), committed words only
//  host_rd_en   in   1   pop strobe; ignored while host_empty
//  host_empty   out  1   no committed words in EP6
//  pkt_count    out  8   EP6 packets committed, wraps at 255->0
//  err_flags    out  3   sticky: [0] EP6 overflow, [1] EP2 underflow, [2] bus contention
// BEHAVIOUR
//  Reset: both FIFOs flushed; FLAG_EMPTY=1, FLAG_FULL=0, host_full=0, host_empty=1,
//   pkt_count=0, err_flags=0, FD=Z. Reset mid-transfer discards all in-flight words.
//  FD drive: FD = EP2 head word when SLOE=1 && FIFOADR==00; FD = 16'h0000 if EP2 is empty.
//   FD = Z otherwise.
//  Read: at an edge with SLRD=1 && FIFOADR==00, pop EP2. The master samples FD during the SLRD-high
//   cycle, so the head word is valid before the strobe. Pop while empty -> no pop, err[1]=1.
//  Write: at an edge with SLWR=1 && FIFOADR==10, push FD into EP6. Push while full -> word dropped,
//   err[0]=1.
//  Strobes with any other FIFOADR are ignored. SLWR=1 while SLOE=1 -> write ignored, err[2]=1.
//  Flags are registered from next-cycle occupancy. They are therefore accurate in the cycle after
//   each push or pop, with zero added lag. Simultaneous host push and master pop on EP2 are both
//   honoured; the count is unchanged.
//  EP6 commit: the uncommitted count (ucnt) increments per accepted master write.
//   - ucnt reaching PKT_WORDS -> auto-commit.
//   - PKTEND=1 with ucnt>0 -> commit; PKTEND with ucnt=0 -> no-op.
//   - A write and PKTEND in the same cycle commit that word too.
//   Commit moves ucnt into the committed count and increments pkt_count. host_empty = committed==0.
//  Pointers wrap modulo 2**DEPTH_LOG2. Occupancy counters are DEPTH_LOG2+1 bits, so full and empty
//   are distinguishable.
//  FSM (EP6 commit tracker): ACCUM (ucnt>0 or idle) -> COMMIT (1 cycle, update counts and
//   pkt_count) -> ACCUM. Bus reads and writes need no FSM; each is a single-edge action.
// STRUCTURE
//  Shared package: EP2_ADR=2'b00, EP6_ADR=2'b10, FRAME_PREFIX=16'h4444, err bit indices.
//  Sub-module: sync_fifo_fwft (params DEPTH_LOG2, WIDTH=16; push/pop/count/head), instantiated
//   once for EP2 and once for EP6. The commit gate around EP6 lives in this module.
// TESTING
//  1 Reset: assert RST=0 mid-stream -> FLAG_EMPTY=1, FLAG_FULL=0, FD=Z, pkt_count=0, err=0.
//  2 Host pushes 4444,0203,AAAA,BBBB,CCCC; master reads -> FD shows the same 5 words in order.
//    FLAG_EMPTY=1 one cycle after the 5th pop.
//  3 Master writes 4444,0003,0001,0002,0003 then PKTEND -> host_empty=0, host reads the 5 words,
//    pkt_count=1.
//  4 Master writes 2**DEPTH_LOG2 words -> FLAG_FULL=1; extra SLWR -> word dropped, err[0]=1.
//  5 Master writes PKT_WORDS words, no PKTEND -> auto-commit, pkt_count=1; PKTEND with ucnt=0 ->
//    pkt_count unchanged.
//  6 SLRD on empty EP2 with SLOE=1 -> FD=0000, err[1]=1. SLWR with SLOE=1 -> err[2]=1, EP6 unchanged.

Source files
------------

// File: rtl/fx2_slave_fifo_responder_pkg.sv
// Shared constants and types for the FX2 slave-FIFO responder.
package fx2_slave_fifo_responder_pkg;

    // FIFOADR codes recognised on the slave-FIFO bus
    localparam logic [1:0]  EP2_ADR      = 2'b00;
    localparam logic [1:0]  EP6_ADR      = 2'b10;

    // First word of every frame exchanged with the host
    localparam logic [15:0] FRAME_PREFIX = 16'h4444;

    // Bit positions inside err_flags
    localparam int ERR_EP6_OVF  = 0;
    localparam int ERR_EP2_UDF  = 1;
    localparam int ERR_BUS_CONT = 2;

    // EP6 commit tracker states
    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_COMMIT = 1'b1
    } commit_state_e;

    // Assemble one cycle's error events into err_flags bit order
    function automatic logic [2:0] err_vec(input logic ovf, input logic udf, input logic cont);
        logic [2:0] v;
        v               = 3'b000;
        v[ERR_EP6_OVF]  = ovf;
        v[ERR_EP2_UDF]  = udf;
        v[ERR_BUS_CONT] = cont;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The caller only pushes when
// there is room and only pops when there is data; the head word is visible
// combinationally from the read pointer. The next-cycle occupancy is
// exported so the caller can register its flags with no added lag.
module sync_fifo_fwft #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count_nxt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Occupancy after this edge; a simultaneous push and pop cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_count  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage array; contents need no reset because occupancy gates every use
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/fx2_slave_fifo_responder.sv
// FX2-side slave-FIFO responder: EP2 is filled by the host port and read by
// the bus master; EP6 is written by the bus master and drained by the host
// port once words have been committed as packets.
module fx2_slave_fifo_responder
    import fx2_slave_fifo_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_WORDS  = 256
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [15:0] FD,
    input  logic        SLOE,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic [1:0]  FIFOADR,
    input  logic        PKTEND,
    output logic        FLAG_EMPTY,
    output logic        FLAG_FULL,
    input  logic [15:0] host_wr_data,
    input  logic        host_wr_en,
    output logic        host_full,
    output logic [15:0] host_rd_data,
    input  logic        host_rd_en,
    output logic        host_empty,
    output logic [7:0]  pkt_count,
    output logic [2:0]  err_flags
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0] CNT_PKT  = CW'(PKT_WORDS);

    logic          w_ep2_sel, w_ep6_sel;
    logic          w_ep2_push, w_ep2_pop, w_ep2_udf;
    logic          w_wr_req, w_bus_cont, w_ep6_ovf, w_ep6_push, w_host_pop;
    logic [15:0]   w_ep2_head, w_ep6_head, w_fd_out;
    logic [CW-1:0] w_ep2_cnt_nxt, w_ep6_cnt_nxt;

    logic          r_flag_empty, r_flag_full, r_host_full, r_host_empty;
    logic [2:0]    r_err;

    commit_state_e r_state, w_state_nxt;
    logic [CW-1:0] r_ucnt, r_ccnt, r_pend;
    logic [CW-1:0] w_ucnt_acc, w_ucnt_nxt, w_ccnt_nxt, w_pend_nxt;
    logic          w_commit_req;
    logic [7:0]    r_pkt_count, w_pkt_nxt;

    // Bus and host strobe qualification against current flags
    always_comb begin
        w_ep2_sel  = (FIFOADR == EP2_ADR);
        w_ep6_sel  = (FIFOADR == EP6_ADR);
        w_ep2_pop  = SLRD && w_ep2_sel && !r_flag_empty;
        w_ep2_udf  = SLRD && w_ep2_sel && r_flag_empty;
        w_ep2_push = host_wr_en && !r_host_full;
        w_wr_req   = SLWR && w_ep6_sel;
        w_bus_cont = w_wr_req && SLOE;
        w_ep6_ovf  = w_wr_req && !SLOE && r_flag_full;
        w_ep6_push = w_wr_req && !SLOE && !r_flag_full;
        w_host_pop = host_rd_en && !r_host_empty;
        if (r_flag_empty) begin
            w_fd_out = 16'h0000;
        end else begin
            w_fd_out = w_ep2_head;
        end
    end

    // Responder only drives the bus for EP2 while the master has released it
    assign FD = (RST && SLOE && w_ep2_sel) ? w_fd_out : 16'hzzzz;

    sync_fifo_fwft #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(16)) u_ep2 (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_push      (w_ep2_push),
        .i_data      (host_wr_data),
        .i_pop       (w_ep2_pop),
        .o_head      (w_ep2_head),
        .o_count_nxt (w_ep2_cnt_nxt)
    );

    sync_fifo_fwft #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(16)) u_ep6 (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_push      (w_ep6_push),
        .i_data      (FD),
        .i_pop       (w_host_pop),
        .o_head      (w_ep6_head),
        .o_count_nxt (w_ep6_cnt_nxt)
    );

    // EP6 commit tracker: a commit request parks the packet size in r_pend,
    // and the COMMIT cycle moves it into the host-visible committed count
    always_comb begin
        if (w_ep6_push) begin
            w_ucnt_acc = r_ucnt + CNT_ONE;
        end else begin
            w_ucnt_acc = r_ucnt;
        end
        w_commit_req = (w_ucnt_acc == CNT_PKT) || (PKTEND && (w_ucnt_acc != CNT_ZERO));
        if (w_commit_req) begin
            w_ucnt_nxt = CNT_ZERO;
            w_pend_nxt = w_ucnt_acc;
        end else begin
            w_ucnt_nxt = w_ucnt_acc;
            w_pend_nxt = r_pend;
        end
        w_state_nxt = r_state;
        w_ccnt_nxt  = r_ccnt;
        w_pkt_nxt   = r_pkt_count;
        case (r_state)
            ST_ACCUM: begin
                if (w_commit_req) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_COMMIT: begin
                w_ccnt_nxt = r_ccnt + r_pend;
                w_pkt_nxt  = r_pkt_count + 8'd1;
                if (w_commit_req) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
        if (w_host_pop) begin
            w_ccnt_nxt = w_ccnt_nxt - CNT_ONE;
        end else begin
            w_ccnt_nxt = w_ccnt_nxt;
        end
    end

    // Commit tracker state and counters
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_ACCUM;
            r_ucnt      <= CNT_ZERO;
            r_ccnt      <= CNT_ZERO;
            r_pend      <= CNT_ZERO;
            r_pkt_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ucnt      <= w_ucnt_nxt;
            r_ccnt      <= w_ccnt_nxt;
            r_pend      <= w_pend_nxt;
            r_pkt_count <= w_pkt_nxt;
        end
    end

    // Flags registered from next-cycle occupancy, plus sticky error bits
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_flag_empty <= 1'b1;
            r_host_full  <= 1'b0;
            r_flag_full  <= 1'b0;
            r_host_empty <= 1'b1;
            r_err        <= 3'b000;
        end else begin
            r_flag_empty <= (w_ep2_cnt_nxt == CNT_ZERO);
            r_host_full  <= (w_ep2_cnt_nxt == CNT_FULL);
            r_flag_full  <= (w_ep6_cnt_nxt == CNT_FULL);
            r_host_empty <= (w_ccnt_nxt == CNT_ZERO);
            r_err        <= r_err | err_vec(w_ep6_ovf, w_ep2_udf, w_bus_cont);
        end
    end

    assign FLAG_EMPTY   = r_flag_empty;
    assign FLAG_FULL    = r_flag_full;
    assign host_full    = r_host_full;
    assign host_empty   = r_host_empty;
    assign host_rd_data = r_host_empty ? 16'h0000 : w_ep6_head;
    assign pkt_count    = r_pkt_count;
    assign err_flags    = r_err;

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Directed bench for the FX2 slave-FIFO responder with a queue-based model
// that is compared against the outputs on every falling edge.
module tb_fx2_slave_fifo_responder;
    import fx2_slave_fifo_responder_pkg::*;

    localparam int DEPTH = 512;
    localparam int PKT   = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    wire  [15:0] FD;
    logic        SLOE = 1'b0, SLRD = 1'b0, SLWR = 1'b0, PKTEND = 1'b0;
    logic [1:0]  FIFOADR = 2'b01;
    logic [15:0] tb_fd = 16'hA5A5;
    logic [15:0] host_wr_data = 16'h0000;
    logic        host_wr_en = 1'b0, host_rd_en = 1'b0;
    logic        FLAG_EMPTY, FLAG_FULL, host_full, host_empty;
    logic [15:0] host_rd_data;
    logic [7:0]  pkt_count;
    logic [2:0]  err_flags;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // master side of the shared bus
    assign FD = (!SLOE) ? tb_fd : 16'hzzzz;

    fx2_slave_fifo_responder #(.DEPTH_LOG2(9), .PKT_WORDS(PKT)) dut (
        .CLK(CLK), .RST(RST), .FD(FD), .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR),
        .FIFOADR(FIFOADR), .PKTEND(PKTEND), .FLAG_EMPTY(FLAG_EMPTY), .FLAG_FULL(FLAG_FULL),
        .host_wr_data(host_wr_data), .host_wr_en(host_wr_en), .host_full(host_full),
        .host_rd_data(host_rd_data), .host_rd_en(host_rd_en), .host_empty(host_empty),
        .pkt_count(pkt_count), .err_flags(err_flags)
    );

    always #5 CLK = ~CLK;

    // reference model: plain queues and counts
    logic [15:0] m_ep2[$];
    logic [15:0] m_ep6[$];
    int          m_ccnt = 0, m_ucnt = 0, m_pend = 0;
    bit          m_pend_v = 1'b0;
    logic [7:0]  m_pkt = 8'd0;
    logic [2:0]  m_err = 3'b000;

    task automatic model_reset();
        m_ep2.delete(); m_ep6.delete();
        m_ccnt = 0; m_ucnt = 0; m_pend = 0; m_pend_v = 1'b0;
        m_pkt = 8'd0; m_err = 3'b000;
    endtask

    task automatic model_update();
        bit e2, f2, f6;
        int cpre;
        if (!RST) begin
            model_reset();
        end else begin
            e2 = (m_ep2.size() == 0); f2 = (m_ep2.size() == DEPTH);
            f6 = (m_ep6.size() == DEPTH); cpre = m_ccnt;
            if (SLRD && FIFOADR == 2'b00) begin
                if (e2) m_err[ERR_EP2_UDF] = 1'b1;
                else void'(m_ep2.pop_front());
            end
            if (host_wr_en && !f2) m_ep2.push_back(host_wr_data);
            if (host_rd_en && cpre > 0) begin
                void'(m_ep6.pop_front());
                m_ccnt = m_ccnt - 1;
            end
            if (m_pend_v) begin
                m_ccnt = m_ccnt + m_pend;
                m_pkt  = m_pkt + 8'd1;
            end
            if (SLWR && FIFOADR == 2'b10) begin
                if (SLOE) m_err[ERR_BUS_CONT] = 1'b1;
                else if (f6) m_err[ERR_EP6_OVF] = 1'b1;
                else begin
                    m_ep6.push_back(FD);
                    m_ucnt = m_ucnt + 1;
                end
            end
            if ((PKTEND && m_ucnt > 0) || m_ucnt == PKT) begin
                m_pend_v = 1'b1; m_pend = m_ucnt; m_ucnt = 0;
            end else begin
                m_pend_v = 1'b0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        tick(); tick();
        RST = 1'b1;
    endtask

    // every-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("FLAG_EMPTY", 16'(FLAG_EMPTY), 16'(m_ep2.size() == 0));
            check("host_full",  16'(host_full),  16'(m_ep2.size() == DEPTH));
            check("FLAG_FULL",  16'(FLAG_FULL),  16'(m_ep6.size() == DEPTH));
            check("host_empty", 16'(host_empty), 16'(m_ccnt == 0));
            check("host_rd_data", host_rd_data, (m_ccnt > 0) ? m_ep6[0] : 16'h0000);
            check("pkt_count", 16'(pkt_count), 16'(m_pkt));
            check("err_flags", 16'(err_flags), 16'(m_err));
            if (!SLOE) check("fd_released", FD, tb_fd);
            else if (RST && FIFOADR == 2'b00)
                check("fd_drive", FD, (m_ep2.size() > 0) ? m_ep2[0] : 16'h0000);
        end
    end

    logic [15:0] w2 [5] = '{FRAME_PREFIX, 16'h0203, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    logic [15:0] w3 [5] = '{FRAME_PREFIX, 16'h0003, 16'h0001, 16'h0002, 16'h0003};

    initial begin
        #2;
        RST = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick(); tick();
        RST = 1'b1;

        // 1: reset in the middle of traffic
        host_wr_en = 1'b1; host_wr_data = 16'h1111;
        FIFOADR = 2'b10; SLWR = 1'b1; tb_fd = 16'h2222;
        tick(); tick();
        host_wr_en = 1'b0;
        #3 check("fd_released_lit", FD, 16'h2222);
        RST = 1'b0;
        model_reset();
        #1;
        check("rst_flag_empty", 16'(FLAG_EMPTY), 16'h0001);
        check("rst_flag_full",  16'(FLAG_FULL),  16'h0000);
        check("rst_pkt",        16'(pkt_count),  16'h0000);
        check("rst_err",        16'(err_flags),  16'h0000);
        check("rst_host_empty", 16'(host_empty), 16'h0001);
        SLWR = 1'b0; FIFOADR = 2'b01;
        tick(); tick();
        RST = 1'b1;

        // 2: EP2 host push, master read, including overlapping push and pop
        host_wr_en = 1'b1; host_wr_data = w2[0]; tick();
        host_wr_data = w2[1]; tick();
        #3 check("ep2_not_empty", 16'(FLAG_EMPTY), 16'h0000);
        SLOE = 1'b1; FIFOADR = 2'b00; SLRD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_wr_en = (i < 3);
            if (i < 3) host_wr_data = w2[i+2];
            #3 check("ep2_fd_word", FD, w2[i]);
            tick();
        end
        SLRD = 1'b0; host_wr_en = 1'b0;
        #3 check("ep2_empty_after", 16'(FLAG_EMPTY), 16'h0001);
        SLOE = 1'b0; FIFOADR = 2'b01;
        tick();

        // 3: EP6 packet via PKTEND, then write+PKTEND in the same cycle
        FIFOADR = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tb_fd = w3[i]; SLWR = 1'b1; tick();
        end
        SLWR = 1'b0; PKTEND = 1'b1; tick();
        PKTEND = 1'b0; tick();
        #3 check("ep6_host_empty", 16'(host_empty), 16'h0000);
        check("ep6_pkt1", 16'(pkt_count), 16'h0001);
        host_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3 check("ep6_word", host_rd_data, w3[i]);
            tick();
        end
        host_rd_en = 1'b0;
        tb_fd = 16'h0E01; SLWR = 1'b1; tick();
        tb_fd = 16'h0E02; PKTEND = 1'b1; tick();
        SLWR = 1'b0; PKTEND = 1'b0; tick();
        #3 check("ep6_pkt2", 16'(pkt_count), 16'h0002);
        host_rd_en = 1'b1; tick(); tick(); host_rd_en = 1'b0;
        #3 check("ep6_drained", 16'(host_empty), 16'h0001);

        // 4: fill EP6, overflow
        do_reset();
        SLOE = 1'b0; FIFOADR = 2'b10; SLWR = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tb_fd = 16'(i) ^ 16'h5A00; tick();
        end
        #3 check("ep6_full", 16'(FLAG_FULL), 16'h0001);
        tb_fd = 16'hDEAD; tick();
        SLWR = 1'b0;
        #3 check("ovf_err", 16'(err_flags), 16'h0001);
        check("ovf_full", 16'(FLAG_FULL), 16'h0001);
        check("ovf_pkt", 16'(pkt_count), 16'h0002);
        check("ovf_head", host_rd_data, 16'h5A00);
        host_rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        host_rd_en = 1'b0;
        #3 check("ovf_drained", 16'(host_empty), 16'h0001);
        check("ovf_not_full", 16'(FLAG_FULL), 16'h0000);

        // 5: auto-commit, then PKTEND with nothing pending
        do_reset();
        FIFOADR = 2'b10; SLWR = 1'b1;
        for (int i = 0; i < PKT; i++) begin
            tb_fd = 16'(i) + 16'h0100; tick();
        end
        SLWR = 1'b0; tick();
        #3 check("auto_pkt", 16'(pkt_count), 16'h0001);
        check("auto_host_empty", 16'(host_empty), 16'h0000);
        PKTEND = 1'b1; tick(); PKTEND = 1'b0; tick(); tick();
        #3 check("noop_pkt", 16'(pkt_count), 16'h0001);

        // 6: underflow, foreign address, contention
        do_reset();
        SLOE = 1'b1; FIFOADR = 2'b01; SLRD = 1'b1; tick();
        #3 check("foreign_adr_err", 16'(err_flags), 16'h0000);
        FIFOADR = 2'b00;
        #1 check("udf_fd_zero", FD, 16'h0000);
        tick();
        SLRD = 1'b0;
        #3 check("udf_err", 16'(err_flags), 16'h0002);
        FIFOADR = 2'b10; SLWR = 1'b1; tick();
        SLWR = 1'b0; PKTEND = 1'b1; tick(); PKTEND = 1'b0; tick(); tick();
        #3 check("cont_err", 16'(err_flags), 16'h0006);
        check("cont_host_empty", 16'(host_empty), 16'h0001);
        check("cont_pkt", 16'(pkt_count), 16'h0000);
        SLOE = 1'b0; FIFOADR = 2'b01;
        tick(); tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
